imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Parametrised, registered immediate generator for the decode stage. It accepts a 32-bit
//  instruction and its PC over a valid/ready handshake. It emits the sign-extended XLEN-wide
//  immediate, a format tag, the PC-relative target (pc+imm), and an illegal-encoding flag.
//  It sits between fetch and decode/execute. A 2-entry skid buffer gives full throughput
//  under backpressure. It adds XLEN generalisation and CSR zimm support.
// PARAMETERS
//  XLEN      32  datapath width; 32 or 64 (imm and PC widths)
//  EN_ZICSR  1   1: decode SYSTEM funct3[2]=1 as 5-bit zero-extended zimm; 0: fmt NONE
// PORTS
//  clk            in   1     clock, rising edge
//  rst_n          in   1     asynchronous active-low reset
//  flush          in   1     synchronous pipeline flush
//  in_valid       in   1     input handshake valid
//  in_ready       out  1     input handshake ready
//  in_instr       in   32    instruction word
//  in_pc          in   XLEN  instruction PC
//  out_valid      out  1     output handshake valid
//  out_ready      in   1     output handshake ready
//  out_imm        out  XLEN  immediate, sign-extended to XLEN (zimm zero-extended)
//  out_fmt        out  3     NONE=0 I=1 S=2 B=3 U=4 J=5 Z=6
//  out_target     out  XLEN  out_pc + out_imm, modulo 2^XLEN
//  out_illegal    out  1     opcode[1:0]!=2'b11 or unknown opcode
// BEHAVIOUR
//  - Format decode by opcode:
//    I = OP-IMM/LOAD/JALR; S = STORE; B = BRANCH; U = LUI/AUIPC; J = JAL;
//    Z = SYSTEM with funct3[2]=1 and EN_ZICSR=1.
//    Bit fields are the RV32I ones. Sign bit is instr[31] for every format except Z.
//    U: {instr[31:12],12'b0}, then sign-extended to XLEN.
//  - Unknown opcode: imm=0, fmt=NONE, illegal=1. Illegal entries still flow through the pipe.
//  - Decode and add are combinational on the input side. Results are registered.
//    Latency: 1 cycle from accept to out_valid.
//  - Storage: main reg (M) plus skid reg (K).
//    States: EMPTY (M,K invalid), ONE (M valid), FULL (M,K valid).
//    in_ready = !K.valid (registered state only, no combinational path from out_ready).
//    EMPTY: accept -> ONE.
//    ONE: accept & pop -> ONE with new data. Accept & !pop -> FULL, data into K.
//      Pop & !accept -> EMPTY.
//    FULL: pop -> ONE, K moves to M. No accept is possible.
//  - Ordering is strictly FIFO. No entry is dropped or duplicated.
//  - out_* is stable while out_valid & !out_ready.
//  - flush has priority over every transfer. Next state = EMPTY.
//    An in_valid & in_ready beat in the flush cycle is discarded.
//  - Reset (async assert, sync deassert handled upstream) forces:
//    out_valid=0, in_ready=1, out_imm/out_target=0, out_fmt=NONE, out_illegal=0.
//    Reset mid-transfer discards all held entries.
//  - XLEN=64: the adder is 64-bit and wraps. XLEN=32: wraps at 2^32.
// STRUCTURE
//  - The shared defines file holds the opcode constants, the FMT_* codes, and the 3-bit fmt width.
//  - Sub-module imm_gen_core: combinational {instr,pc} -> {imm,fmt,target,illegal}, XLEN-parametrised.
//    The top level holds only the M/K registers and the handshake FSM.
// TESTING
//  1. XLEN=32, ADDI 0xFFF00093 pc=0x0 -> next cycle: imm=0xFFFFFFFF, fmt=I, illegal=0.
//  2. BEQ 0xFE000EE3, pc=0x100 -> imm=0xFFFFFFFC, fmt=B, target=0x000000FC.
//  3. XLEN=64, LUI 0x800000B7 -> imm=0xFFFFFFFF80000000, fmt=U.
//     CSRRWI 0x300FD073 -> imm=0x1F, fmt=Z.
//  4. Hold out_ready=0 and push 3 back-to-back -> in_ready=0 after 2 accepts.
//     Release out_ready -> outputs appear in order, 1 per cycle, 3rd accepted.
//  5. In FULL state, assert flush together with in_valid=1 -> next cycle out_valid=0,
//     in_ready=1, no stale output.
//  6. Assert rst_n=0 mid-stream while FULL -> all outputs take reset values asynchronously.
//     Instr 0x00000000 -> illegal=1, fmt=NONE, imm=0.

Source files
------------

// File: rtl/imm_gen_pipe_pkg.sv
// Shared decode constants for the immediate generator: opcodes, format codes and
// the opcode classifier used by the combinational core.
package imm_gen_pipe_pkg;

    localparam int FMT_W = 3;

    typedef enum logic [FMT_W-1:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } fmt_e;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef struct packed {
        fmt_e fmt;
        logic illegal;
    } dec_class_t;

    // OP and MISC-MEM are legal RV32I encodings that carry no immediate for this stage,
    // so they decode as NONE without raising illegal.
    function automatic dec_class_t classify(input logic [6:0] opcode,
                                            input logic       csr_imm_sel,
                                            input bit         en_zicsr);
        dec_class_t c;
        c.fmt     = FMT_NONE;
        c.illegal = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: c.fmt = FMT_I;
            OPC_STORE:                      c.fmt = FMT_S;
            OPC_BRANCH:                     c.fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:             c.fmt = FMT_U;
            OPC_JAL:                        c.fmt = FMT_J;
            OPC_SYSTEM:                     c.fmt = (en_zicsr && csr_imm_sel) ? FMT_Z : FMT_NONE;
            OPC_OP, OPC_MISC_MEM:           c.fmt = FMT_NONE;
            default:                        c.illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Fetch-side and decode-side handshake bundle of the immediate generator.
interface imm_gen_pipe_if
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = 32
) ();

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_pc;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [FMT_W-1:0] out_fmt;
    logic [XLEN-1:0]  out_target;
    logic             out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal
    );

endinterface

// File: rtl/imm_gen_pipe_core.sv
// Combinational decode: instruction and PC in, immediate/format/target/illegal out.
module imm_gen_core
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit EN_ZICSR = 1'b1
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic [XLEN-1:0] target,
    output logic            illegal
);

    dec_class_t cls;
    logic       unused_funct3_lo;

    assign cls              = classify(instr[6:0], instr[14], EN_ZICSR);
    assign unused_funct3_lo = ^instr[13:12];

    // Signed size casts do the sign extension to XLEN; zimm is the only zero-extended field.
    // NOTE: every output of a combinational block gets a default first, otherwise an
    // unassigned path through the case infers a latch.
    always_comb begin
        imm = '0;
        case (cls.fmt)
            FMT_I:   imm = XLEN'($signed(instr[31:20]));
            FMT_S:   imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            FMT_B:   imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            FMT_U:   imm = XLEN'($signed({instr[31:12], 12'b0}));
            FMT_J:   imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            FMT_Z:   imm = XLEN'(instr[19:15]);
            default: imm = '0;
        endcase
    end

    assign fmt     = cls.fmt;
    assign illegal = cls.illegal;
    assign target  = pc + imm;

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decode core feeding a main register and a skid
// register, giving full throughput with a fully registered in_ready.
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit EN_ZICSR = 1'b1
) (
    input logic           clk,
    input logic           rst_n,
    input logic           flush,
    imm_gen_pipe_if.slave bus
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]      state, state_nxt;
    logic            accept, pop;
    logic            m_ld_in, m_ld_k, k_ld;

    logic [XLEN-1:0] d_imm, d_target;
    fmt_e            d_fmt;
    logic            d_illegal;

    logic [XLEN-1:0] m_imm, m_target, k_imm, k_target;
    fmt_e            m_fmt, k_fmt;
    logic            m_illegal, k_illegal;

    imm_gen_core #(
        .XLEN     (XLEN),
        .EN_ZICSR (EN_ZICSR)
    ) u_core (
        .instr   (bus.in_instr),
        .pc      (bus.in_pc),
        .imm     (d_imm),
        .fmt     (d_fmt),
        .target  (d_target),
        .illegal (d_illegal)
    );

    // in_ready depends on registered state only, so out_ready never reaches it combinationally.
    assign bus.in_ready  = (state != ST_FULL);
    assign bus.out_valid = (state != ST_EMPTY);
    assign accept        = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    always_comb begin
        state_nxt = state;
        m_ld_in   = 1'b0;
        m_ld_k    = 1'b0;
        k_ld      = 1'b0;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_nxt = ST_ONE;
                        m_ld_in   = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        m_ld_in = 1'b1;
                    end else if (accept) begin
                        state_nxt = ST_FULL;
                        k_ld      = 1'b1;
                    end else if (pop) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_nxt = ST_ONE;
                        m_ld_k    = 1'b1;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    // NOTE: sequential state is assigned with non-blocking <= so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the data registers are reset (not left uninitialised) because M drives the
    // outputs directly and their reset values are visible to the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_imm     <= '0;
            m_target  <= '0;
            m_fmt     <= FMT_NONE;
            m_illegal <= 1'b0;
        end else if (flush) begin
            m_imm     <= '0;
            m_target  <= '0;
            m_fmt     <= FMT_NONE;
            m_illegal <= 1'b0;
        end else if (m_ld_in) begin
            m_imm     <= d_imm;
            m_target  <= d_target;
            m_fmt     <= d_fmt;
            m_illegal <= d_illegal;
        end else if (m_ld_k) begin
            m_imm     <= k_imm;
            m_target  <= k_target;
            m_fmt     <= k_fmt;
            m_illegal <= k_illegal;
        end
    end

    // K contents are meaningless outside FULL, so flush only needs to clear the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_imm     <= '0;
            k_target  <= '0;
            k_fmt     <= FMT_NONE;
            k_illegal <= 1'b0;
        end else if (k_ld) begin
            k_imm     <= d_imm;
            k_target  <= d_target;
            k_fmt     <= d_fmt;
            k_illegal <= d_illegal;
        end
    end

    assign bus.out_imm     = m_imm;
    assign bus.out_target  = m_target;
    assign bus.out_fmt     = m_fmt;
    assign bus.out_illegal = m_illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an XLEN=32 (no zimm) and an XLEN=64 (zimm) instance share one
// stimulus stream and are checked every cycle against a depth-2 FIFO model.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush;
    logic        in_valid;
    logic [31:0] instr;
    logic [63:0] pc;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32)) b32 ();
    imm_gen_pipe_if #(.XLEN(64)) b64 ();

    assign b32.in_valid  = in_valid;
    assign b32.in_instr  = instr;
    assign b32.in_pc     = pc[31:0];
    assign b32.out_ready = out_ready;
    assign b64.in_valid  = in_valid;
    assign b64.in_instr  = instr;
    assign b64.in_pc     = pc;
    assign b64.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(32), .EN_ZICSR(1'b0)) u_dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (b32.slave)
    );

    imm_gen_pipe #(.XLEN(64), .EN_ZICSR(1'b1)) u_dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (b64.slave)
    );

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } beat_t;

    beat_t q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: handshake did not complete within the cycle budget at %0t", name, $time);
    endtask

    // Reference decode from the ISA field definitions using 64-bit arithmetic, then
    // truncated to the instance width.
    function automatic void model(input logic [31:0] ins, input logic [63:0] pc_in,
                                  input int xlen, input bit zicsr,
                                  output logic [63:0] imm, output logic [2:0] fmt,
                                  output logic [63:0] tgt, output logic ill);
        longint      si;
        logic [63:0] mask;
        logic [6:0]  opc;
        si   = longint'($signed(ins));
        opc  = ins[6:0];
        imm  = '0;
        fmt  = 3'd0;
        ill  = 1'b0;
        case (opc)
            7'h03, 7'h13, 7'h67: begin fmt = 3'd1; imm = si >>> 20; end
            7'h23: begin fmt = 3'd2; imm = ((si >>> 25) <<< 5) | longint'(ins[11:7]); end
            7'h63: begin
                fmt = 3'd3;
                imm = ((si >>> 31) <<< 12) | (longint'(ins[7]) << 11)
                    | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
            end
            7'h37, 7'h17: begin fmt = 3'd4; imm = (si >>> 12) <<< 12; end
            7'h6F: begin
                fmt = 3'd5;
                imm = ((si >>> 31) <<< 20) | (longint'(ins[19:12]) << 12)
                    | (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
            end
            7'h73: if (zicsr && ins[14]) begin fmt = 3'd6; imm = longint'(ins[19:15]); end
            7'h33, 7'h0F: fmt = 3'd0;
            default: ill = 1'b1;
        endcase
        mask = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        imm  = imm & mask;
        tgt  = ((pc_in & mask) + imm) & mask;
    endfunction

    task automatic cmp_dut(input string tag, input logic v, input logic r,
                           input logic [63:0] imm, input logic [2:0] fmt,
                           input logic [63:0] tgt, input logic ill,
                           input int xlen, input bit zicsr);
        logic [63:0] ei, et;
        logic [2:0]  ef;
        logic        el;
        check({tag, "_out_valid"}, 64'(v), 64'(q.size() != 0));
        check({tag, "_in_ready"}, 64'(r), 64'(q.size() < 2));
        if (q.size() != 0) begin
            model(q[0].instr, q[0].pc, xlen, zicsr, ei, ef, et, el);
            check({tag, "_imm"}, imm, ei);
            check({tag, "_fmt"}, 64'(fmt), 64'(ef));
            check({tag, "_target"}, tgt, et);
            check({tag, "_illegal"}, 64'(ill), 64'(el));
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_valid32"}, 64'(b32.out_valid), 64'd0);
        check({tag, "_ready32"}, 64'(b32.in_ready), 64'd1);
        check({tag, "_imm32"}, {32'b0, b32.out_imm}, 64'd0);
        check({tag, "_tgt32"}, {32'b0, b32.out_target}, 64'd0);
        check({tag, "_fmt32"}, 64'(b32.out_fmt), 64'd0);
        check({tag, "_ill32"}, 64'(b32.out_illegal), 64'd0);
        check({tag, "_valid64"}, 64'(b64.out_valid), 64'd0);
        check({tag, "_ready64"}, 64'(b64.in_ready), 64'd1);
        check({tag, "_imm64"}, b64.out_imm, 64'd0);
        check({tag, "_tgt64"}, b64.out_target, 64'd0);
        check({tag, "_fmt64"}, 64'(b64.out_fmt), 64'd0);
        check({tag, "_ill64"}, 64'(b64.out_illegal), 64'd0);
    endtask

    // Compare process: check what the DUTs show now, then advance the model by the
    // handshake that the coming rising edge will perform.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            check_reset("rst");
        end else begin
            cmp_dut("d32", b32.out_valid, b32.in_ready, {32'b0, b32.out_imm}, b32.out_fmt,
                    {32'b0, b32.out_target}, b32.out_illegal, 32, 1'b0);
            cmp_dut("d64", b64.out_valid, b64.in_ready, b64.out_imm, b64.out_fmt,
                    b64.out_target, b64.out_illegal, 64, 1'b1);
            if (flush) begin
                q.delete();
            end else begin
                automatic bit do_pop = (q.size() != 0) && out_ready;
                automatic bit do_acc = in_valid && (q.size() < 2);
                if (do_pop) void'(q.pop_front());
                if (do_acc) q.push_back('{instr: instr, pc: pc});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!b32.in_ready) begin
            if (n == 50) begin
                fail_timeout(name);
                break;
            end
            n++;
            tick();
        end
    endtask

    task automatic send(input logic [31:0] ins, input logic [63:0] p);
        in_valid = 1'b1;
        instr    = ins;
        pc       = p;
        wait_ready("send");
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while (b32.out_valid || b64.out_valid) begin
            if (n == 20) begin
                fail_timeout("drain");
                break;
            end
            n++;
            tick();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    logic [31:0] vins[16];
    logic [63:0] vpc[16];
    logic [7:0]  pat;

    initial begin
        flush     = 1'b0;
        in_valid  = 1'b0;
        instr     = '0;
        pc        = '0;
        out_ready = 1'b0;
        #2;
        check_reset("por");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // ADDI with all-ones immediate
        out_ready = 1'b1;
        send(32'hFFF0_0093, 64'h0);
        @(negedge clk);
        check("addi_valid", 64'(b32.out_valid), 64'd1);
        check("addi_imm", {32'b0, b32.out_imm}, 64'hFFFF_FFFF);
        check("addi_fmt", 64'(b32.out_fmt), 64'd1);
        check("addi_ill", 64'(b32.out_illegal), 64'd0);
        check("addi_tgt", {32'b0, b32.out_target}, 64'hFFFF_FFFF);
        tick();

        // backwards BEQ
        send(32'hFE00_0EE3, 64'h100);
        @(negedge clk);
        check("beq_imm", {32'b0, b32.out_imm}, 64'hFFFF_FFFC);
        check("beq_fmt", 64'(b32.out_fmt), 64'd3);
        check("beq_tgt", {32'b0, b32.out_target}, 64'h0000_00FC);
        tick();

        // LUI sign extends to 64 bits
        send(32'h8000_00B7, 64'h0);
        @(negedge clk);
        check("lui64_imm", b64.out_imm, 64'hFFFF_FFFF_8000_0000);
        check("lui64_fmt", 64'(b64.out_fmt), 64'd4);
        check("lui32_imm", {32'b0, b32.out_imm}, 64'h8000_0000);
        tick();

        // CSRRWI: zimm on the 64-bit instance, plain SYSTEM on the one without zimm
        send(32'h300F_D073, 64'h0);
        @(negedge clk);
        check("csr64_imm", b64.out_imm, 64'h1F);
        check("csr64_fmt", 64'(b64.out_fmt), 64'd6);
        check("csr32_fmt", 64'(b32.out_fmt), 64'd0);
        check("csr32_imm", {32'b0, b32.out_imm}, 64'd0);
        check("csr32_ill", 64'(b32.out_illegal), 64'd0);
        tick();

        // all-zero word is illegal
        send(32'h0000_0000, 64'h40);
        @(negedge clk);
        check("zero_ill", 64'(b64.out_illegal), 64'd1);
        check("zero_fmt", 64'(b64.out_fmt), 64'd0);
        check("zero_imm", b64.out_imm, 64'd0);
        tick();

        // backpressure: two accepts fill the pipe, the third waits
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h0010_0093;
        pc        = 64'h10;
        tick();
        instr = 32'h0020_0093;
        tick();
        instr = 32'h0030_0093;
        check("bp_ready32_full", 64'(b32.in_ready), 64'd0);
        check("bp_ready64_full", 64'(b64.in_ready), 64'd0);
        tick();
        @(negedge clk);
        check("bp_hold_imm", {32'b0, b32.out_imm}, 64'd1);
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_first", {32'b0, b32.out_imm}, 64'd1);
        tick();
        @(negedge clk);
        check("bp_second", {32'b0, b32.out_imm}, 64'd2);
        check("bp_ready_again", 64'(b32.in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_third", {32'b0, b32.out_imm}, 64'd3);
        tick();
        drain();

        // flush while FULL with a beat offered
        out_ready = 1'b0;
        send(32'h0040_0093, 64'h0);
        send(32'h0050_0093, 64'h0);
        in_valid = 1'b1;
        instr    = 32'h0060_0093;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_full_valid", 64'(b64.out_valid), 64'd0);
        check("flush_full_ready", 64'(b64.in_ready), 64'd1);
        tick();

        // flush while ONE: the accepted-looking beat is discarded
        send(32'h0070_0093, 64'h0);
        in_valid = 1'b1;
        instr    = 32'h0080_0093;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_one_valid", 64'(b32.out_valid), 64'd0);
        tick();
        tick();

        // asynchronous reset while FULL
        send(32'h0090_0093, 64'h0);
        send(32'h00A0_0093, 64'h0);
        #2 rst_n = 1'b0;
        #1 check_reset("async");
        tick();
        rst_n = 1'b1;
        tick();

        // streaming with irregular backpressure
        vins[0]  = 32'h0011_2623; vpc[0]  = 64'h1000;
        vins[1]  = 32'hFE11_2E23; vpc[1]  = 64'h1004;
        vins[2]  = 32'h0100_006F; vpc[2]  = 64'h1008;
        vins[3]  = 32'hFFDF_F0EF; vpc[3]  = 64'h100C;
        vins[4]  = 32'h0000_1517; vpc[4]  = 64'h1010;
        vins[5]  = 32'h0000_8067; vpc[5]  = 64'h1014;
        vins[6]  = 32'hFFC4_A303; vpc[6]  = 64'h1018;
        vins[7]  = 32'h0000_0073; vpc[7]  = 64'h101C;
        vins[8]  = 32'hFFFF_FFFF; vpc[8]  = 64'h1020;
        vins[9]  = 32'h0000_0001; vpc[9]  = 64'h1024;
        vins[10] = 32'h0100_0093; vpc[10] = 64'hFFFF_FFFF_FFFF_FFF0;
        vins[11] = 32'h7FFF_F0B7; vpc[11] = 64'h8000_0000;
        vins[12] = 32'h300F_D073; vpc[12] = 64'h2000;
        vins[13] = 32'h8000_0063; vpc[13] = 64'h0000_0000_0000_0800;
        vins[14] = 32'h8000_006F; vpc[14] = 64'h0000_0001_0000_0000;
        vins[15] = 32'hFFF0_0093; vpc[15] = 64'h0;
        pat = 8'b1101_0110;
        begin
            int i = 0;
            int cyc = 0;
            while (i < 16 && cyc < 200) begin
                in_valid  = 1'b1;
                instr     = vins[i];
                pc        = vpc[i];
                out_ready = pat[cyc % 8];
                if (b32.in_ready) begin
                    tick();
                    i++;
                end else begin
                    tick();
                end
                cyc++;
            end
            if (i < 16) fail_timeout("stream");
        end
        in_valid = 1'b0;
        drain();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
